// File: rtl/gcn_sched_pkg.sv
// Shared types and default sizes for the ADJ x (FM*WM) scheduler slice.
package gcn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } sched_state_t;

  localparam int DEF_NUM_OF_NODES   = 6;
  localparam int DEF_WEIGHT_COLS    = 3;
  localparam int DEF_DOT_PROD_WIDTH = 16;

endpackage

// File: rtl/row_out_reg.sv
// Single-entry valid/ready output register carrying row index, last flag and payload.
module row_out_reg #(
  parameter int ROW_W  = 3,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              out_ready,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              last_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_last,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;

  // The caller only raises load when the slot is empty or being drained.
  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      row_d   = row_in;
      last_d  = last_in;
      data_d  = data_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      row_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_row   = row_q;
  assign out_last  = last_q;
  assign out_data  = data_q;

endmodule

// File: rtl/adj_fmwm_scheduler.sv
// Load/compute sequencer for the ADJ x (FM*WM) datapath: fills the row buffer,
// then streams one registered dot-product row per accepted output beat.
// Handshakes: a beat transfers on a rising edge where valid && ready; the
// producer holds valid and payload stable until that edge.
module adj_fmwm_scheduler
  import gcn_sched_pkg::*;
#(
  parameter int NUM_OF_NODES          = DEF_NUM_OF_NODES,
  parameter int WEIGHT_COLS           = DEF_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH        = DEF_DOT_PROD_WIDTH,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(NUM_OF_NODES)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  dp_enable,
  output logic [COUNTER_FEATURE_WIDTH-1:0]      dp_write_row,
  output logic [COUNTER_FEATURE_WIDTH-1:0]      dp_read_row,
  input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] dp_dot_product,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [COUNTER_FEATURE_WIDTH-1:0]      out_row,
  output logic                                  out_last,
  output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] out_data,
  output logic [1:0]                            dbg_state
);

  localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW =
    COUNTER_FEATURE_WIDTH'(NUM_OF_NODES - 1);

  sched_state_t                     state_q, state_d;
  logic [COUNTER_FEATURE_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [COUNTER_FEATURE_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                             done_q, done_d;
  logic                             load_en;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (wr_cnt_q == LAST_ROW) begin
            wr_cnt_d = '0;
            state_d  = COMPUTE;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (!out_valid || out_ready) begin
          load_en = 1'b1;
          // Return the read pointer to 0 so no out-of-range row is ever driven.
          if (rd_cnt_q == LAST_ROW) begin
            rd_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      done_q   <= done_d;
    end
  end

  row_out_reg #(
    .ROW_W  (COUNTER_FEATURE_WIDTH),
    .DATA_W (WEIGHT_COLS*DOT_PROD_WIDTH)
  ) u_row_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load_en),
    .out_ready (out_ready),
    .row_in    (rd_cnt_q),
    .last_in   (rd_cnt_q == LAST_ROW),
    .data_in   (dp_dot_product),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_last  (out_last),
    .out_data  (out_data)
  );

  assign busy         = (state_q != IDLE);
  assign in_ready     = (state_q == LOAD);
  assign dp_enable    = in_ready && in_valid;
  assign dp_write_row = wr_cnt_q;
  assign dp_read_row  = rd_cnt_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_adj_fmwm_scheduler.sv
// Bench for adj_fmwm_scheduler: a behavioural row-buffer datapath plus a
// scoreboard fed from matrix arithmetic over the rows sent upstream.
module tb_adj_fmwm_scheduler;
  import gcn_sched_pkg::*;

  localparam int N  = 6;
  localparam int C  = 3;
  localparam int W  = 16;
  localparam int CW = 3;
  localparam int DW = C*W;
  localparam int EW = 1 + CW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          busy, done, in_ready, dp_enable, out_valid, out_last;
  logic [CW-1:0] dp_write_row, dp_read_row, out_row;
  logic [DW-1:0] dp_dot_product, out_data;
  logic [1:0]    dbg_state;

  int compared = 0;
  int mismatched = 0;

  int            adj [N][N];
  logic [W-1:0]  sent [N][C];
  logic [W-1:0]  dbuf [N][C];
  logic [EW-1:0] exp_q[$];

  int            load_idx, acc_cnt, done_cnt, busy_cyc, en_cyc, ov_cyc;
  int            stall_cycles, stall_bad;
  logic          last_acc_prev = 1'b0;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out = '0;
  logic [DW-1:0] last_acc_data = '0;

  adj_fmwm_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dp_enable      (dp_enable),
    .dp_write_row   (dp_write_row),
    .dp_read_row    (dp_read_row),
    .dp_dot_product (dp_dot_product),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_row        (out_row),
    .out_last       (out_last),
    .out_data       (out_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  always @(posedge clk) begin
    if (dp_enable && int'(dp_write_row) < N)
      for (int j = 0; j < C; j++) dbuf[int'(dp_write_row)][j] <= in_data[j*W +: W];
  end

  always @* begin
    int r;
    int acc;
    r = (int'(dp_read_row) < N) ? int'(dp_read_row) : 0;
    for (int j = 0; j < C; j++) begin
      acc = 0;
      for (int k = 0; k < N; k++) acc += adj[r][k] * int'(dbuf[k][j]);
      dp_dot_product[j*W +: W] = acc[W-1:0];
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] exp_row(input int r);
    logic [DW-1:0] d;
    int acc;
    for (int j = 0; j < C; j++) begin
      acc = 0;
      for (int k = 0; k < N; k++) acc += adj[r][k] * int'(sent[k][j]);
      d[j*W +: W] = acc[W-1:0];
    end
    return {(r == N-1), CW'(r), d};
  endfunction

  function automatic logic [DW-1:0] pack_row(input int i);
    logic [DW-1:0] d;
    for (int j = 0; j < C; j++) d[j*W +: W] = sent[i][j];
    return d;
  endfunction

  task automatic setup_pass(input int amode, input int dmode);
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++)
        adj[r][k] = (amode == 0) ? int'(r == k) : (amode == 1) ? 1 : int'($urandom_range(0, 3));
      for (int j = 0; j < C; j++) begin
        if (dmode == 0)      sent[r][j] = (j == 0) ? W'(r + 1) : (j == 1) ? W'(2 * r) : W'(7);
        else if (dmode == 1) sent[r][j] = 16'h3000;
        else                 sent[r][j] = W'($urandom_range(0, 65535));
      end
    end
    exp_q.delete();
    for (int r = 0; r < N; r++) exp_q.push_back(exp_row(r));
    load_idx = 0; acc_cnt = 0; done_cnt = 0; busy_cyc = 0; en_cyc = 0; ov_cyc = 0;
    stall_cycles = 0; stall_bad = 0;
  endtask

  // ---------------- scoreboard step (one clock) ----------------
  task automatic step();
    logic [EW-1:0] e;
    logic          cur_last;
    @(negedge clk);
    if (!reset) begin
      last_acc_prev = 1'b0;
      prev_stall    = 1'b0;
    end else begin
      compared++;
      if (in_valid && in_ready) begin
        if (dp_enable !== 1'b1 || int'(dp_write_row) !== load_idx) begin
          mismatched++;
          $display("FAIL load_hs: dp_enable=%0b row=%0d, required 1 row=%0d", dp_enable, dp_write_row, load_idx);
        end
        load_idx++;
      end else if (dp_enable !== 1'b0) begin
        mismatched++;
        $display("FAIL dp_enable_idle: dp_enable=%0b without handshake, required 0", dp_enable);
      end
      if (dbg_state == 2'd2) begin
        compared++;
        if (load_idx !== N) begin
          mismatched++;
          $display("FAIL compute_entry: %0d rows loaded, required %0d", load_idx, N);
        end
      end
      if (prev_stall) begin
        compared++;
        if (out_valid !== 1'b1 || {out_last, out_row, out_data} !== prev_out) begin
          mismatched++;
          $display("FAIL hold_stable: valid=%0b out=%0h, required 1 %0h", out_valid, {out_last, out_row, out_data}, prev_out);
        end
      end
      cur_last = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL out_extra: row=%0d accepted, none expected", out_row);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_row, out_data} !== e) begin
            mismatched++;
            $display("FAIL out_row_data: got %0h, required %0h", {out_last, out_row, out_data}, e);
          end
        end
        acc_cnt++;
        last_acc_data = out_data;
      end
      compared++;
      if (done !== last_acc_prev) begin
        mismatched++;
        $display("FAIL done_timing: done=%0b, required %0b", done, last_acc_prev);
      end
      done_cnt += int'(done);
      busy_cyc += int'(busy);
      en_cyc   += int'(dp_enable);
      ov_cyc   += int'(out_valid);
      last_acc_prev = cur_last;
      prev_stall    = out_valid && !out_ready;
      prev_out      = {out_last, out_row, out_data};
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // vmode/rmode: 0 always high, 1 scripted pattern, 2 random.
  task automatic run_pass(input bit do_start, input int vmode, input int rmode,
                          input bit spam_start, input int budget);
    int k;
    k = 0;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    while (done !== 1'b1 && k < budget) begin
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      if (load_idx < N) in_data = pack_row(load_idx);
      if (rmode == 0)      out_ready = 1'b1;
      else if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
      else if (out_valid && out_row == 3'd2 && stall_cycles < 4) begin
        out_ready = 1'b0;
        stall_cycles++;
        if (dp_read_row !== 3'd3) stall_bad++;
      end else out_ready = 1'b1;
      start = spam_start ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      k++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (done !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL pass_timeout: no done within %0d cycles", budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) step();
    compared++;
    if ({busy, done, in_ready, dp_enable, out_valid, out_last, out_row, out_data,
         dp_write_row, dp_read_row, dbg_state} !== '0) begin
      mismatched++;
      $display("FAIL reset_in: outputs not all zero during reset (busy=%0b ov=%0b st=%0d)", busy, out_valid, dbg_state);
    end
    reset = 1'b1;
    repeat (2) step();
    compared++;
    if ({busy, done, in_ready, dp_enable, out_valid, out_last, out_row, out_data,
         dp_write_row, dp_read_row, dbg_state} !== '0) begin
      mismatched++;
      $display("FAIL reset_idle: outputs not all zero after release (busy=%0b ov=%0b st=%0d)", busy, out_valid, dbg_state);
    end
  endtask

  task automatic test_identity();
    setup_pass(0, 0);
    run_pass(1'b1, 0, 0, 1'b0, 100);
    step();
    compared++;
    if (acc_cnt !== N || done_cnt !== 1 || busy_cyc !== 13 || en_cyc !== N || ov_cyc !== N) begin
      mismatched++;
      $display("FAIL identity_counts: acc=%0d done=%0d busy=%0d en=%0d ov=%0d, required 6 1 13 6 6",
               acc_cnt, done_cnt, busy_cyc, en_cyc, ov_cyc);
    end
    compared++;
    if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL identity_end: done=%0b busy=%0b left=%0d, required 0 0 0", done, busy, exp_q.size());
    end
  endtask

  task automatic test_in_valid_toggle();
    setup_pass(2, 2);
    run_pass(1'b1, 1, 0, 1'b0, 200);
    step();
    compared++;
    if (acc_cnt !== N || done_cnt !== 1 || busy_cyc !== 23 || en_cyc !== N) begin
      mismatched++;
      $display("FAIL toggle_counts: acc=%0d done=%0d busy=%0d en=%0d, required 6 1 23 6",
               acc_cnt, done_cnt, busy_cyc, en_cyc);
    end
  endtask

  task automatic test_backpressure();
    setup_pass(2, 2);
    run_pass(1'b1, 0, 1, 1'b0, 200);
    step();
    compared++;
    if (stall_cycles !== 4 || stall_bad !== 0) begin
      mismatched++;
      $display("FAIL stall_read_row: stalls=%0d bad=%0d, required 4 0", stall_cycles, stall_bad);
    end
    compared++;
    if (acc_cnt !== N || busy_cyc !== 17 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL stall_counts: acc=%0d busy=%0d left=%0d, required 6 17 0", acc_cnt, busy_cyc, exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    setup_pass(2, 2);
    run_pass(1'b1, 0, 0, 1'b1, 100);
    compared++;
    if (acc_cnt !== N || busy_cyc !== 13 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL start_spam: acc=%0d busy=%0d left=%0d, required 6 13 0", acc_cnt, busy_cyc, exp_q.size());
    end
    setup_pass(2, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    compared++;
    if (dbg_state !== 2'd1 || in_ready !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL start_in_done: state=%0d in_ready=%0b busy=%0b, required 1 1 1", dbg_state, in_ready, busy);
    end
    done_cnt = 0;
    run_pass(1'b0, 2, 2, 1'b0, 400);
    step();
    compared++;
    if (acc_cnt !== N || done_cnt !== 1 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL chained_pass: acc=%0d done=%0d left=%0d, required 6 1 0", acc_cnt, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_saturate();
    setup_pass(1, 1);
    run_pass(1'b1, 0, 0, 1'b0, 100);
    step();
    for (int j = 0; j < C; j++) begin
      compared++;
      if (last_acc_data[j*W +: W] !== 16'h2000) begin
        mismatched++;
        $display("FAIL truncated_col%0d: got %0h, required 2000", j, last_acc_data[j*W +: W]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    setup_pass(2, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!(out_valid && out_row == 3'd3) && k < 50) begin
      in_valid = 1'b1;
      if (load_idx < N) in_data = pack_row(load_idx);
      out_ready = 1'b1;
      step();
      k++;
    end
    reset = 1'b0;
    #1;
    compared++;
    if (k >= 50 || {busy, out_valid, dp_read_row, dbg_state, done, in_ready} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: k=%0d busy=%0b ov=%0b rd=%0d st=%0d done=%0b, required all 0",
               k, busy, out_valid, dp_read_row, dbg_state, done);
    end
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    done_cnt = 0;
    repeat (3) step();
    compared++;
    if (done_cnt !== 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_after: done=%0d busy=%0b ov=%0b, required 0 0 0", done_cnt, busy, out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      setup_pass(2, 2);
      run_pass(1'b1, 2, 2, 1'b1, 500);
      step();
      compared++;
      if (acc_cnt !== N || done_cnt !== 1 || exp_q.size() != 0) begin
        mismatched++;
        $display("FAIL random_pass%0d: acc=%0d done=%0d left=%0d, required 6 1 0", it, acc_cnt, done_cnt, exp_q.size());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int r = 0; r < N; r++)
      for (int j = 0; j < C; j++) dbuf[r][j] = '0;
    setup_pass(0, 0);
    exp_q.delete();
    test_reset();
    test_identity();
    test_in_valid_toggle();
    test_backpressure();
    test_start_ignored();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
